// File: rtl/dco_tune_pkg.sv
// Shared definitions for the DCO tuning-word front end.
// Holds the mode/state encoding, default bank sizes and constant helpers
// used to derive mid-code reset values for the matrix code registers.
package dco_tune_pkg;

  // Mode request and FSM state share one encoding.
  typedef enum logic [1:0] {
    MODE_PVT = 2'd0,
    MODE_ACQ = 2'd1,
    MODE_TRK = 2'd2
  } dco_mode_t;

  localparam int unsigned DEF_N_L    = 5;
  localparam int unsigned DEF_N_M    = 16;
  localparam int unsigned DEF_N_S    = 16;
  localparam int unsigned DEF_FRAC_W = 5;

  // Selectors for enc_mask().
  localparam int unsigned ENC_RALL = 0;
  localparam int unsigned ENC_ROW  = 1;
  localparam int unsigned ENC_COL  = 2;

  // Mid-scale code of an n x n bank.
  function automatic int unsigned mid_code(input int unsigned n);
    return (n * n) / 2;
  endfunction

  // Constant-time matrix encoding of v for an n-wide bank (n <= 64),
  // used only to build reset values.
  function automatic logic [63:0] enc_mask(input int unsigned n,
                                           input int unsigned v,
                                           input int unsigned kind);
    logic [63:0] m;
    int unsigned q;
    int unsigned r;
    m = '0;
    q = v / n;
    r = v % n;
    for (int unsigned i = 0; i < n; i++) begin
      case (kind)
        ENC_RALL: m[6'(i)] = (i < q);
        ENC_ROW:  m[6'(i)] = (i == q);
        default:  m[6'(i)] = (i < r);
      endcase
    end
    return m;
  endfunction

endpackage

// File: rtl/cap_mtx_enc.sv
// Combinational value -> row/column/row-all matrix encoder for one bank.
// Values above N*N-1 are clamped. With q = v/N and r = v%N:
//   rall[i] = i < q, row[i] = i == q, col[j] = j < r
// so exactly v cells satisfy rall[i] | (row[i] & col[j]).
// Ports: v (one bit wider than the bank code, to absorb a dither carry),
//        rall_c / row_c / col_c (N bits each).
module cap_mtx_enc
  import dco_tune_pkg::*;
#(
  parameter  int unsigned N  = DEF_N_S,
  localparam int unsigned VW = $clog2(N * N) + 1
) (
  input  logic [VW-1:0] v,
  output logic [N-1:0]  rall_c,
  output logic [N-1:0]  row_c,
  output logic [N-1:0]  col_c
);

  localparam logic [VW-1:0] V_MAX = VW'(N * N - 1);
  localparam logic [VW-1:0] N_V   = VW'(N);

  logic [VW-1:0] v_sat;
  logic [VW-1:0] q;
  logic [VW-1:0] r;

  assign v_sat = (v > V_MAX) ? V_MAX : v;
  assign q     = v_sat / N_V;
  assign r     = v_sat % N_V;

  for (genvar i = 0; i < N; i++) begin : g_bit
    assign rall_c[i] = (VW'(i) < q);
    assign row_c[i]  = (VW'(i) == q);
    assign col_c[i]  = (VW'(i) < r);
  end

endmodule

// File: rtl/dco_tune_ctrl.sv
// Tuning-word front end for the DCO: converts large/medium/small bank OTWs
// into registered matrix codes, with a PVT -> ACQ -> TRK mode FSM deciding
// which bank may load. Optional first-order sigma-delta dither on the small
// bank is enabled by defining DCO_DITHER_EN.
// Ports: clk, rst (sync, active-high), mode, otw_valid, otw_l/m/s in;
//        state, upd, c_{l,m,s}_{rall,row,col} out (all registered).
module dco_tune_ctrl
  import dco_tune_pkg::*;
#(
  parameter  int unsigned N_L    = DEF_N_L,
  parameter  int unsigned N_M    = DEF_N_M,
  parameter  int unsigned N_S    = DEF_N_S,
  parameter  int unsigned FRAC_W = DEF_FRAC_W,
  localparam int unsigned W_L    = $clog2(N_L * N_L),
  localparam int unsigned W_M    = $clog2(N_M * N_M),
  localparam int unsigned W_S    = $clog2(N_S * N_S)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [1:0]            mode,
  input  logic                  otw_valid,
  input  logic [W_L-1:0]        otw_l,
  input  logic [W_M-1:0]        otw_m,
  input  logic [W_S+FRAC_W-1:0] otw_s,
  output logic [1:0]            state,
  output logic                  upd,
  output logic [N_L-1:0]        c_l_rall,
  output logic [N_L-1:0]        c_l_row,
  output logic [N_L-1:0]        c_l_col,
  output logic [N_M-1:0]        c_m_rall,
  output logic [N_M-1:0]        c_m_row,
  output logic [N_M-1:0]        c_m_col,
  output logic [N_S-1:0]        c_s_rall,
  output logic [N_S-1:0]        c_s_row,
  output logic [N_S-1:0]        c_s_col
);

  localparam int unsigned VW_S = W_S + 1;

  localparam logic [W_L-1:0] MID_L = W_L'(mid_code(N_L));
  localparam logic [W_M-1:0] MID_M = W_M'(mid_code(N_M));
  localparam logic [W_S-1:0] MID_S = W_S'(mid_code(N_S));

  localparam logic [N_L-1:0] RST_L_RALL = N_L'(enc_mask(N_L, mid_code(N_L), ENC_RALL));
  localparam logic [N_L-1:0] RST_L_ROW  = N_L'(enc_mask(N_L, mid_code(N_L), ENC_ROW));
  localparam logic [N_L-1:0] RST_L_COL  = N_L'(enc_mask(N_L, mid_code(N_L), ENC_COL));
  localparam logic [N_M-1:0] RST_M_RALL = N_M'(enc_mask(N_M, mid_code(N_M), ENC_RALL));
  localparam logic [N_M-1:0] RST_M_ROW  = N_M'(enc_mask(N_M, mid_code(N_M), ENC_ROW));
  localparam logic [N_M-1:0] RST_M_COL  = N_M'(enc_mask(N_M, mid_code(N_M), ENC_COL));
  localparam logic [N_S-1:0] RST_S_RALL = N_S'(enc_mask(N_S, mid_code(N_S), ENC_RALL));
  localparam logic [N_S-1:0] RST_S_ROW  = N_S'(enc_mask(N_S, mid_code(N_S), ENC_ROW));
  localparam logic [N_S-1:0] RST_S_COL  = N_S'(enc_mask(N_S, mid_code(N_S), ENC_COL));

  dco_mode_t st;
  dco_mode_t nxt;
  dco_mode_t req;
  logic      recentre;

  // Bank registers hold the raw integer part; clamping happens in the encoder.
  logic [W_L-1:0]  v_l;
  logic [W_M-1:0]  v_m;
  logic [W_S-1:0]  v_s;
  logic [VW_S-1:0] v_s_out;

  logic [N_L-1:0] l_rall_c, l_row_c, l_col_c;
  logic [N_M-1:0] m_rall_c, m_row_c, m_col_c;
  logic [N_S-1:0] s_rall_c, s_row_c, s_col_c;
  logic           code_chg_c;

  assign state = st;

  // Mode request decode; 3 aliases to TRK.
  always_comb begin
    req = MODE_TRK;
    case (mode)
      2'd0:    req = MODE_PVT;
      2'd1:    req = MODE_ACQ;
      default: req = MODE_TRK;
    endcase
  end

  // Next state: forward moves and PVT returns are taken, TRK->ACQ is not.
  always_comb begin
    nxt = st;
    case (st)
      MODE_PVT: nxt = req;
      MODE_ACQ: nxt = req;
      MODE_TRK: nxt = (req == MODE_PVT) ? MODE_PVT : MODE_TRK;
      default:  nxt = MODE_PVT;
    endcase
  end

  assign recentre = (st != MODE_PVT) && (nxt == MODE_PVT);

`ifdef DCO_DITHER_EN
  logic [FRAC_W-1:0] frac_s;
  logic [FRAC_W-1:0] acc;
  logic [FRAC_W:0]   acc_sum;
  logic              carry;

  assign acc_sum = {1'b0, acc} + {1'b0, frac_s};
  assign carry   = (st == MODE_TRK) && acc_sum[FRAC_W];
  assign v_s_out = {1'b0, v_s} + VW_S'(carry);

  // Fraction of the accepted small-bank word and its phase accumulator.
  always_ff @(posedge clk) begin
    if (rst) begin
      frac_s <= '0;
      acc    <= '0;
    end else begin
      if (otw_valid && (st == MODE_TRK)) frac_s <= otw_s[FRAC_W-1:0];
      if (recentre) begin
        frac_s <= '0;
        acc    <= '0;
      end else if (st == MODE_TRK) begin
        acc <= acc_sum[FRAC_W-1:0];
      end
    end
  end
`else
  logic unused_frac;
  assign unused_frac = ^otw_s[FRAC_W-1:0];
  assign v_s_out     = {1'b0, v_s};
`endif

  cap_mtx_enc #(.N(N_L)) u_enc_l (
    .v      ({1'b0, v_l}),
    .rall_c (l_rall_c),
    .row_c  (l_row_c),
    .col_c  (l_col_c)
  );

  cap_mtx_enc #(.N(N_M)) u_enc_m (
    .v      ({1'b0, v_m}),
    .rall_c (m_rall_c),
    .row_c  (m_row_c),
    .col_c  (m_col_c)
  );

  cap_mtx_enc #(.N(N_S)) u_enc_s (
    .v      (v_s_out),
    .rall_c (s_rall_c),
    .row_c  (s_row_c),
    .col_c  (s_col_c)
  );

  assign code_chg_c = (l_rall_c != c_l_rall) || (l_row_c != c_l_row) || (l_col_c != c_l_col) ||
                      (m_rall_c != c_m_rall) || (m_row_c != c_m_row) || (m_col_c != c_m_col) ||
                      (s_rall_c != c_s_rall) || (s_row_c != c_s_row) || (s_col_c != c_s_col);

  // State, bank registers and registered matrix codes.
  always_ff @(posedge clk) begin
    if (rst) begin
      st       <= MODE_PVT;
      v_l      <= MID_L;
      v_m      <= MID_M;
      v_s      <= MID_S;
      upd      <= 1'b0;
      c_l_rall <= RST_L_RALL;
      c_l_row  <= RST_L_ROW;
      c_l_col  <= RST_L_COL;
      c_m_rall <= RST_M_RALL;
      c_m_row  <= RST_M_ROW;
      c_m_col  <= RST_M_COL;
      c_s_rall <= RST_S_RALL;
      c_s_row  <= RST_S_ROW;
      c_s_col  <= RST_S_COL;
    end else begin
      st <= nxt;
      // The bank of the current (old) state owns an incoming OTW.
      if (otw_valid) begin
        case (st)
          MODE_PVT: v_l <= otw_l;
          MODE_ACQ: v_m <= otw_m;
          MODE_TRK: v_s <= otw_s[W_S+FRAC_W-1:FRAC_W];
          default:  ;
        endcase
      end
      // Returning to PVT re-centres the finer banks, overriding a same-cycle load.
      if (recentre) begin
        v_m <= MID_M;
        v_s <= MID_S;
      end
      upd      <= code_chg_c;
      c_l_rall <= l_rall_c;
      c_l_row  <= l_row_c;
      c_l_col  <= l_col_c;
      c_m_rall <= m_rall_c;
      c_m_row  <= m_row_c;
      c_m_col  <= m_col_c;
      c_s_rall <= s_rall_c;
      c_s_row  <= s_row_c;
      c_s_col  <= s_col_c;
    end
  end

endmodule
